// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/load-store memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DPRIO_MAX = 3;

  typedef enum logic [1:0] {
    RSEL_NONE,
    RSEL_I,
    RSEL_D
  } rsel_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port of the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  i_req;
  logic [31:0]           i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic [DATA_W/8-1:0]   d_we;
  logic [31:0]           d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Counts consecutive data wins while fetch is waiting; at_max hands the next
// contested cycle to fetch.
module starve_ctr #(
  parameter int DPRIO_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic d_win,
  output logic at_max
);

  localparam int CW = $clog2(DPRIO_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_wait) begin
      cnt_d = '0;
    end else if (d_win) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CW'(DPRIO_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of a 1-cycle-latency
// single-port word memory; load/store has priority, bounded by starve_ctr.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DPRIO_MAX = DEF_DPRIO_MAX
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  rsel_t             rsel_q, rsel_d;
  logic              at_max;
  logic              i_gnt, d_gnt, i_wait;
  logic              i_rv, d_rv;
  logic [ADDR_W-1:0] i_word, d_word;
  logic              unused_addr_bits;

  assign i_word = bus.i_addr[ADDR_W+1:2];
  assign d_word = bus.d_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (bus.i_req && bus.d_req) begin
        i_gnt = at_max;
        d_gnt = !at_max;
      end else begin
        i_gnt = bus.i_req;
        d_gnt = bus.d_req;
      end
    end
  end

  assign i_wait = bus.i_req && !i_gnt;

  starve_ctr #(.DPRIO_MAX(DPRIO_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .i_wait (i_wait),
    .d_win  (d_gnt),
    .at_max (at_max)
  );

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (i_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = i_word;
    end else if (d_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = d_word;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    rsel_d = RSEL_NONE;
    if (i_gnt) begin
      rsel_d = RSEL_I;
    end else if (d_gnt && (bus.d_we == '0)) begin
      rsel_d = RSEL_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsel_q <= RSEL_NONE;
    end else begin
      rsel_q <= rsel_d;
    end
  end

  // Gating with reset drops a response whose grant preceded the reset cycle.
  assign i_rv = !reset && (rsel_q == RSEL_I);
  assign d_rv = !reset && (rsel_q == RSEL_D);

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rv;
  assign bus.d_rvalid = d_rv;
  assign bus.i_rdata  = i_rv ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata  = d_rv ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// model of grants, starvation limit and memory contents.
module tb_mem_arbiter;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int DPRIO_MAX = 3;
  localparam int NB        = DATA_W / 8;
  localparam int DEPTH     = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DPRIO_MAX (DPRIO_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Write-first synchronous RAM attached to the memory port.
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_w;
  initial begin
    for (int k = 0; k < DEPTH; k++) ram[k] = 32'h1000 + k;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        ram_w = ram[bus.mem_addr];
        for (int b = 0; b < NB; b++)
          if (bus.mem_we[b]) ram_w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        ram[bus.mem_addr] <= ram_w;
        bus.mem_rdata     <= ram_w;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                m_waits;     // consecutive cycles fetch lost to data
  int                m_pend;      // 0 none, 1 fetch response due, 2 load response due
  logic [DATA_W-1:0] m_pend_data;

  logic              obs_ig, obs_dg;
  logic [ADDR_W-1:0] obs_mem_addr;
  logic [DATA_W-1:0] obs_d_rdata;

  task automatic step();
    logic eig, edg, eiv, edv;
    int   ia, da;
    @(negedge clk);
    ia = (bus.i_addr >> 2) % DEPTH;
    da = (bus.d_addr >> 2) % DEPTH;
    if (reset) begin
      eig = 0; edg = 0;
    end else if (bus.i_req && bus.d_req) begin
      eig = (m_waits >= DPRIO_MAX);
      edg = !eig;
    end else begin
      eig = bus.i_req; edg = bus.d_req;
    end
    eiv = !reset && (m_pend == 1);
    edv = !reset && (m_pend == 2);

    check_eq("i_gnt", bus.i_gnt, eig);
    check_eq("d_gnt", bus.d_gnt, edg);
    check_eq("mem_en", bus.mem_en, eig | edg);
    check_eq("mem_addr", bus.mem_addr, eig ? ia : (edg ? da : 0));
    check_eq("mem_we", bus.mem_we, (!eig && edg) ? bus.d_we : '0);
    check_eq("mem_wdata", bus.mem_wdata, (!eig && edg) ? bus.d_wdata : '0);
    check_eq("i_rvalid", bus.i_rvalid, eiv);
    check_eq("d_rvalid", bus.d_rvalid, edv);
    check_eq("i_rdata", bus.i_rdata, eiv ? m_pend_data : '0);
    check_eq("d_rdata", bus.d_rdata, edv ? m_pend_data : '0);
    check_eq("one_rvalid", bus.i_rvalid & bus.d_rvalid, 0);
    obs_ig = bus.i_gnt;
    obs_dg = bus.d_gnt;
    obs_mem_addr = bus.mem_addr;
    obs_d_rdata = bus.d_rdata;

    if (reset) begin
      m_waits = 0;
      m_pend  = 0;
    end else begin
      m_pend = 0;
      if (eig) begin
        check_eq("fetch_wait_bound", m_waits <= DPRIO_MAX, 1);
        m_pend = 1;
        m_pend_data = ref_mem[ia];
      end else if (edg) begin
        if (bus.d_we == '0) begin
          m_pend = 2;
          m_pend_data = ref_mem[da];
        end else begin
          for (int b = 0; b < NB; b++)
            if (bus.d_we[b]) ref_mem[da][8*b +: 8] = bus.d_wdata[8*b +: 8];
        end
      end
      if (!bus.i_req || eig) m_waits = 0;
      else if (edg) m_waits++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [NB-1:0] we,
                         input logic [31:0] da, input logic [DATA_W-1:0] wd);
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
  endtask

  logic [11:0] pat, exp_pat;

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h1000 + k;
    m_waits = 0; m_pend = 0; m_pend_data = '0;

    // Reset with both requesters active: no grants allowed.
    reset = 1'b1;
    set_req(1, 32'h4, 1, '0, 32'h8, '0);
    step();
    step();
    reset = 1'b0;
    set_req(0, 0, 0, '0, 0, '0);
    step();

    // Fetch-only sweep across all words, then wrap at 0x80.
    for (int k = 0; k <= DEPTH; k++) begin
      set_req(1, 32'(4 * k), 0, '0, 0, '0);
      step();
    end
    check_eq("wrap_addr", obs_mem_addr, 0);
    set_req(0, 0, 0, '0, 0, '0);
    step();

    // Continuous contention: D,D,D,I repeating.
    set_req(1, 32'h10, 1, '0, 32'h20, '0);
    for (int c = 0; c < 12; c++) begin
      step();
      pat[c]     = obs_ig;
      exp_pat[c] = (c % 4 == 3);
    end
    check_eq("dddi_pattern", 32'(pat), 32'(exp_pat));
    set_req(0, 0, 0, '0, 0, '0);
    step();

    // Partial write over a known word, then read it back.
    set_req(0, 0, 1, 4'hF, 32'h08, 32'h11223344);
    step();
    set_req(0, 0, 1, 4'b0011, 32'h08, 32'hAABBCCDD);
    step();
    set_req(0, 0, 1, 4'h0, 32'h08, '0);
    step();
    set_req(0, 0, 0, '0, 0, '0);
    step();
    check_eq("raw_data", obs_d_rdata, 32'h1122CCDD);

    // Alternating fetch and load reads back to back.
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) set_req(1, 32'(8 * c), 0, '0, 0, '0);
      else            set_req(0, 0, 1, '0, 32'(12 * c), '0);
      step();
    end
    set_req(0, 0, 0, '0, 0, '0);
    step();

    // Reset right after a load grant taken with two prior data wins.
    set_req(1, 32'h14, 1, '0, 32'h18, '0);
    step();
    step();
    step();
    check_eq("pre_rst_d", obs_dg, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_eq("post_rst_d", obs_dg, 1);
    set_req(0, 0, 0, '0, 0, '0);
    step();

    // Idle window.
    for (int c = 0; c < 10; c++) step();

    // Randomized traffic honouring hold-until-grant.
    obs_ig = 0; obs_dg = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.i_req || obs_ig) begin
        bus.i_req  = ($urandom_range(0, 3) != 0);
        bus.i_addr = $urandom;
      end
      if (!bus.d_req || obs_dg) begin
        bus.d_req   = ($urandom_range(0, 1) != 0);
        bus.d_we    = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      step();
    end
    set_req(0, 0, 0, '0, 0, '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port synchronous word memory between the rv32i instruction-fetch port and its load/store port. It sits between the processor and the program/data memory, replacing the direct pc-to-rom connection. It grants at most one access per cycle and routes the 1-cycle-latency read data back to the correct requester. Load/store normally wins, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 5, memory word-address width (2^ADDR_W words)
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits
- DPRIO_MAX, 3, max consecutive data grants while fetch is waiting; 1..15
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request valid
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request valid
- d_we  in  DATA_W/8  byte write strobes; all-zero means read
- d_addr  in  32  data byte address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (reads only)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  DATA_W/8  memory byte strobes
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- Handshake: requester holds req/addr/we/wdata stable until gnt=1. The request completes in the cycle where req && gnt. No backpressure on responses.
- Word address = byte addr[ADDR_W+1:2]. addr[1:0] and bits above ADDR_W+1 are ignored, so out-of-range addresses wrap.
- Arbitration (combinational, per cycle):
  - Only one req: that requester is granted.
  - Both req: d is granted unless starve_cnt == DPRIO_MAX, in which case i is granted.
  - Neither: no grant, mem_en=0.
- starve_cnt (register, width clog2(DPRIO_MAX+1)) is updated on each edge, in this order:
  - 0 if i is granted or i_req=0.
  - Otherwise +1 if d is granted while i_req=1.
  - Otherwise held.
- mem_* is driven from the granted requester. For a fetch grant, mem_we=0 and mem_wdata=0. With no grant, all mem_* outputs are 0.
- Response routing register rsel ∈ {NONE, I, D}:
  - Set to I on a fetch grant.
  - Set to D on a data read grant.
  - Set to NONE otherwise, including data writes.
- i_rvalid = (rsel==I). d_rvalid = (rsel==D). Both rdata outputs = mem_rdata when their rvalid is high, else 0.

## Timing
- Grant is combinational in the request cycle. Read data arrives exactly 1 cycle after the grant. A write is complete at the grant edge.
- Throughput is 1 access/cycle. A new grant in cycle t+1 overlaps the return of the cycle-t read.
- Read-after-write to the same word in consecutive cycles returns the new data. This relies on the memory being write-first-in-order; the arbiter adds no forwarding.
- While reset=1: i_gnt=d_gnt=0 and mem_en=0. At the reset edge, starve_cnt=0, rsel=NONE, and therefore i_rvalid=d_rvalid=0 and both rdata=0.
- A read granted in the cycle before reset rises has its response dropped: rvalid stays 0 in the reset cycle.
- Grants resume in the first cycle with reset=0.

## Structure
- Package mem_arb_pkg:
  - enum rsel_t {RSEL_NONE, RSEL_I, RSEL_D}
  - default constants ADDR_W=5, DATA_W=32, DPRIO_MAX=3
- Sub-module starve_ctr holds starve_cnt, with inputs i_wait and d_win and output at_max.
- Everything else (grant logic, mux, rsel register) stays in mem_arbiter.

## Test plan
- Fetch only, with i_addr 0x00,0x04,…,0x7C held per grant and memory preloaded word k = 0x1000+k.
  - Required: i_gnt every cycle, mem_addr 0..31, i_rvalid 1 cycle later with i_rdata 0x1000..0x101F.
  - Then i_addr=0x80 must yield mem_addr 0 (wrap).
- Continuous d_req reads plus continuous i_req, DPRIO_MAX=3.
  - Required grant pattern D,D,D,I repeating; every fetch waits ≤3 cycles.
- Data write followed by read of the same word: d_we=4'b0011, addr 0x08, wdata 0xAABBCCDD over old value 0x11223344.
  - Required: no d_rvalid for the write; the read returns 0x1122CCDD.
- Back-to-back mixed traffic, alternating I read and D read.
  - Required: each rvalid appears on the correct port only, exactly 1 cycle after its grant, never both high.
- Reset asserted for 1 cycle immediately after a D read grant with starve_cnt=2.
  - Required: d_rvalid stays 0, no grants during reset, and after reset both requesting gives D (counter back to 0).
- Idle: no requests for 10 cycles.
  - Required: mem_en=0, all mem_* = 0, rvalid=0, starve_cnt remains 0.
